// File: rtl/gen_scanout_pkg.sv
// Shared types and sizing for the generation datapath.
// The grid is 16x16, and cell (r,c) is at bit r*COLS+c.
package gen_pkg;

  localparam int ROWS   = 16;
  localparam int COLS   = 16;
  localparam int GRID_W = ROWS * COLS;
  localparam int CNT_W  = 9;
  localparam int IDX_W  = 4;
  localparam int POP_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/gen_scanout_if.sv
// Row-stream handshake from the scan-out block to a display driver.
// The master drives data, index and valid, and the slave drives ready.
interface gen_scanout_if;

  logic [gen_pkg::COLS-1:0]  row_data;
  logic [gen_pkg::IDX_W-1:0] row_idx;
  logic                      row_valid;
  logic                      row_ready;

  modport master (output row_data, output row_idx, output row_valid, input row_ready);
  modport slave  (input row_data, input row_idx, input row_valid, output row_ready);

endinterface

// File: rtl/gen_scanout_row_popcount.sv
// Combinational population count of one grid row. Other grid-statistics
// blocks can reuse it.
module row_popcount
  import gen_pkg::*;
#(
  parameter int W  = COLS,
  parameter int CW = POP_W
) (
  input  logic [W-1:0]  row_i,
  output logic [CW-1:0] count_o
);

  // NOTE: assign a default before the loop. Then every path writes count_o
  // and no latch is inferred.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(row_i[i]);
    end
  end

endmodule

// File: rtl/gen_scanout.sv
// Snapshots the generation grid and streams it out one row per transfer.
// It also counts the live cells in the rows that have been transferred.
module gen_scanout
  import gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [GRID_W-1:0] grid_in,
  input  logic              grid_load,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  live_count,
  output logic              overrun,
  gen_scanout_if.master     row_if
);

  scan_state_e       state_q;
  logic [GRID_W-1:0] snapshot_q;
  logic [IDX_W-1:0]  row_idx_q;
  logic [CNT_W-1:0]  live_count_q;
  logic              overrun_q;

  logic [COLS-1:0]   row_data;
  logic [POP_W-1:0]  row_pop;
  logic [CNT_W-1:0]  live_count_d;
  logic              transfer;

  assign row_data     = snapshot_q[row_idx_q*COLS +: COLS];
  assign transfer     = (state_q == SEND) && row_if.row_ready;
  assign live_count_d = live_count_q + CNT_W'(row_pop);

  row_popcount #(.W(COLS), .CW(POP_W)) u_row_popcount (
    .row_i   (row_data),
    .count_o (row_pop)
  );

  // NOTE: the snapshot is a plain register, not a RAM. It resets to zero, so
  // row_data is defined even before the first load.
  // NOTE: use non-blocking assignments here. Every register then samples the
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      snapshot_q   <= '0;
      row_idx_q    <= '0;
      live_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grid_load) begin
            snapshot_q   <= grid_in;
            row_idx_q    <= '0;
            live_count_q <= '0;
            overrun_q    <= 1'b0;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (grid_load) overrun_q <= 1'b1;
          if (transfer) begin
            live_count_q <= live_count_d;
            if (row_idx_q == IDX_W'(ROWS - 1)) state_q   <= DONE;
            else                               row_idx_q <= row_idx_q + 1'b1;
          end
        end
        DONE: begin
          if (grid_load) overrun_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // These outputs decode the state register directly. A mid-frame reset
  // therefore clears them at once and no frame_done is issued.
  assign row_if.row_valid = (state_q == SEND);
  assign row_if.row_data  = row_data;
  assign row_if.row_idx   = row_idx_q;
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == DONE);
  assign live_count       = live_count_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_gen_scanout.sv
// Self-checking bench for gen_scanout: table-driven frames, hand-written corner
// sequences, and randomized frames checked against a row-slice/popcount model.
module tb_gen_scanout;
  import gen_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [GRID_W-1:0] grid_in;
  logic              grid_load;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  live_count;
  logic              overrun;

  int n_vec  = 0;
  int n_fail = 0;

  gen_scanout_if bus ();

  gen_scanout dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .grid_in    (grid_in),
    .grid_load  (grid_load),
    .busy       (busy),
    .frame_done (frame_done),
    .live_count (live_count),
    .overrun    (overrun),
    .row_if     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [GRID_W-1:0] grid;
    int                mode;     // 0 ready always, 1 random ready, 2 stall on row 4
    int                exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [GRID_W-1:0] act,
                       input logic [GRID_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [GRID_W-1:0] g);
    grid_in   = g;
    grid_load = 1'b1;
    @(negedge clk);
    grid_load = 1'b0;
    check("valid_latency", bus.row_valid, 1);
  endtask

  // Stream one frame that is already loaded, starting at a negedge with
  // row 0 presented. The expected rows are plain slices of g, and the expected
  // count is supplied by the caller.
  task automatic stream(input logic [GRID_W-1:0] g, input int exp_cnt, input int mode,
                        input int zero_at, input int load_at);
    int exp_r = 0;
    int cyc   = 0;
    int stall = 0;
    bit pulsed = 0;
    bit rdy;
    while (exp_r < ROWS && cyc < 400) begin
      check("row_valid", bus.row_valid, 1);
      check("row_idx", bus.row_idx, exp_r);
      check("row_data", bus.row_data, g[exp_r*COLS +: COLS]);
      check("busy_send", busy, 1);
      check("no_early_done", frame_done, 0);
      check("overrun_send", overrun, pulsed);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin
          if (exp_r == 4 && stall < 3) begin rdy = 1'b0; stall++; end
          else rdy = 1'b1;
        end
      endcase
      if (exp_r == zero_at) grid_in = '0;
      if (exp_r == load_at && !pulsed) begin
        grid_in   = ~g;
        grid_load = 1'b1;
        pulsed    = 1;
      end
      bus.row_ready = rdy;
      @(negedge clk);
      grid_load = 1'b0;
      if (rdy) exp_r++;
      cyc++;
    end
    check("frame_budget", exp_r, ROWS);
    bus.row_ready = 1'b0;
    check("frame_done", frame_done, 1);
    check("done_valid", bus.row_valid, 0);
    check("done_busy", busy, 1);
    check("done_count", live_count, exp_cnt);
    check("done_overrun", overrun, pulsed);
    @(negedge clk);
    check("done_pulse_end", frame_done, 0);
    check("idle_busy", busy, 0);
    check("idle_count_hold", live_count, exp_cnt);
  endtask

  vec_t              vecs[5];
  logic [GRID_W-1:0] g;

  initial begin
    reset_n       = 1'b0;
    grid_in       = '0;
    grid_load     = 1'b0;
    bus.row_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.row_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", bus.row_idx, 0);
    check("rst_count", live_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_valid", bus.row_valid, 0);
    end

    g = '0; g[1] = 1; g[18] = 1; g[32] = 1; g[33] = 1; g[34] = 1;
    vecs[0] = '{grid: g, mode: 0, exp_cnt: 5};
    vecs[1] = '{grid: {GRID_W{1'b1}}, mode: 2, exp_cnt: 256};
    vecs[2] = '{grid: {ROWS{16'hAAAA}}, mode: 1, exp_cnt: 128};
    g = '0; g[GRID_W-1] = 1;
    vecs[3] = '{grid: g, mode: 0, exp_cnt: 1};
    vecs[4] = '{grid: '0, mode: 1, exp_cnt: 0};

    g = vecs[0].grid;
    check("glider_row0", g[15:0], 16'h0002);
    check("glider_row2", g[47:32], 16'h0007);

    foreach (vecs[i]) begin
      load(vecs[i].grid);
      stream(vecs[i].grid, vecs[i].exp_cnt, vecs[i].mode, -1, -1);
    end

    // Snapshot isolation: grid_in goes to zero during row 2.
    for (int w = 0; w < GRID_W / 32; w++) g[w*32 +: 32] = $urandom;
    load(g);
    stream(g, $countones(g), 1, 2, -1);

    // Overrun: a load during row 7 is ignored, and the next accepted load clears the flag.
    for (int w = 0; w < GRID_W / 32; w++) g[w*32 +: 32] = $urandom;
    load(g);
    stream(g, $countones(g), 0, -1, 7);
    check("overrun_idle", overrun, 1);
    load(vecs[0].grid);
    check("overrun_cleared", overrun, 0);
    stream(vecs[0].grid, 5, 0, -1, -1);

    // Reset mid-frame during row 9.
    g = {GRID_W{1'b1}};
    load(g);
    bus.row_ready = 1'b1;
    repeat (9) @(negedge clk);
    check("pre_rst_idx", bus.row_idx, 9);
    bus.row_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid", bus.row_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", live_count, 0);
    check("midrst_idx", bus.row_idx, 0);
    @(negedge clk);
    check("midrst_no_done", frame_done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", frame_done, 0);
    load(vecs[2].grid);
    stream(vecs[2].grid, 128, 0, -1, -1);

    // Randomized frames checked against the model.
    for (int f = 0; f < 20; f++) begin
      for (int w = 0; w < GRID_W / 32; w++) g[w*32 +: 32] = $urandom & $urandom;
      load(g);
      stream(g, $countones(g), 1, -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_scanout.md
Name: gen_scanout

Overview:
Reader side of the generation datapath. It snapshots the 256-bit grid produced by the generation engine and streams it out one 16-bit row per transfer on a valid/ready interface, toward the LED-matrix or display driver. While streaming it also counts live cells, so software and display logic get a per-frame population figure. The snapshot decouples scan-out from the engine, which may advance to the next generation while a frame is still being sent.

Parameters:
ROWS, 16, number of grid rows
COLS, 16, cells per row (row width)
CNT_W, 9, live-count width; must hold ROWS*COLS (256)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
grid_in  in  ROWS*COLS  current generation; cell (r,c) = grid_in[r*COLS+c]
grid_load  in  1  snapshot request; accepted only in IDLE
busy  out  1  high in SEND and DONE
row_data  out  COLS  current row = snapshot[row_idx*COLS +: COLS]
row_idx  out  4  index of the row on row_data
row_valid  out  1  row_data/row_idx valid
row_ready  in  1  sink accepts the row
frame_done  out  1  one-cycle pulse after the last row transfers
live_count  out  CNT_W  live cells transferred in the current or last frame
overrun  out  1  sticky; a grid_load arrived while busy

Behaviour:
- Reset (async, reset_n=0): state=IDLE; snapshot=0; row_idx=0; row_valid=0; busy=0; frame_done=0; live_count=0; overrun=0.
- States: IDLE, SEND, DONE (enum in package).
- IDLE:
  - On grid_load=1 at a clk edge: snapshot<=grid_in, row_idx<=0, live_count<=0, overrun<=0, go to SEND.
  - Latency: row_valid rises the cycle after grid_load.
- SEND:
  - row_valid=1.
  - Transfer occurs at an edge where row_valid & row_ready; then live_count += popcount(row_data).
  - If row_idx < ROWS-1: row_idx increments. If row_idx == ROWS-1: go to DONE.
  - row_valid & !row_ready: row_data and row_idx are held stable, with no bubble and no drop.
  - row_valid never deasserts before the transfer completes.
  - Back-to-back ready: one row per cycle, 16 cycles per frame.
- DONE:
  - Single cycle; frame_done=1, row_valid=0, live_count final.
  - Next state is IDLE unconditionally.
  - A grid_load in DONE is treated as "while busy".
- grid_load while busy (SEND or DONE): ignored; snapshot unchanged; overrun<=1.
- overrun clears only on the next accepted grid_load.
- live_count holds its final value in IDLE until the next accepted load.
- row_data is combinational from snapshot and row_idx. In IDLE it shows the last-selected row; the sink must ignore it because row_valid=0.
- Changes on grid_in after the snapshot edge have no effect on the frame in progress.
- Width: live_count max is 256, which fits in CNT_W=9 with no wrap. The adder is CNT_W wide with the zero-extended popcount.
- reset_n asserted mid-frame: outputs return to reset values immediately (async). No frame_done is issued; the partial frame is discarded.

Decomposition:
- Shared package gen_pkg: ROWS, COLS, GRID_W=ROWS*COLS, CNT_W, scan state typedef (IDLE, SEND, DONE).
- Sub-module row_popcount: combinational, COLS-bit input, 5-bit count output; reusable by other grid statistics blocks.
- Top: FSM, snapshot register, row counter, live-count accumulator, overrun flag.

Test Plan:
1. Reset then idle: reset_n=0 for 2 cycles, then 1 → all outputs 0; row_valid stays 0 with no grid_load.
2. Full glider frame: grid_in has bits 1,18,32,33,34 set; grid_load pulse; row_ready=1 → row_valid the next cycle; 16 rows idx 0..15. row0=0x0002, row1=0x0004, row2=0x0007, others 0. frame_done pulses one cycle after row 15; live_count=5.
3. Backpressure: all-ones grid; row_ready low 3 cycles during row 4 → row_idx=4 and row_data=0xFFFF held. Frame completes; live_count=256 (0x100).
4. Snapshot isolation: load pattern A; change grid_in to all-zeros during row 2 → remaining rows still from A; live_count equals popcount(A).
5. Overrun: grid_load pulsed during SEND row 7 → overrun=1; frame unaffected. Next IDLE grid_load → overrun=0, new frame starts.
6. Reset mid-frame: reset_n=0 during row 9 → row_valid, busy, live_count=0 immediately; no frame_done. After release, a new grid_load streams from row 0.
